// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU fetch slice: word width and fetch FSM encodings.
package hack_pkg;

  localparam int WORD_W = 16;

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO holding {instruction, address} pairs; flush empties it in one cycle.
module fetch_queue #(
  parameter int ENTRY_W = 32,
  parameter int DEPTH   = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [ENTRY_W-1:0]         push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic [ENTRY_W-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;

  // DEPTH is a power of two, so pointer wrap is the natural overflow of AW bits
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/hack_fetch.sv
// Hack CPU instruction-fetch controller: drives the PC, prefetches from a synchronous ROM,
// and hands instructions downstream over valid/ready. Optional counters: HACK_FETCH_PERF_EN.
module hack_fetch
  import hack_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_out,
  output logic             pc_reset,
  output logic             pc_load,
  output logic             pc_inc,
  output logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_data,
  input  logic             jmp_valid,
  input  logic [WIDTH-1:0] jmp_target,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready
`ifdef HACK_FETCH_PERF_EN
  ,
  output logic [WIDTH-1:0] fetch_cnt,
  output logic [WIDTH-1:0] flush_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t             state;
  logic               inflight;
  logic [WIDTH-1:0]   inflight_pc;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] head;
  logic               run;
  logic               deq;
  logic               flush;
  logic               push;
  logic               issue;
  logic [CW:0]        occ;

  assign run   = (state == S_RUN);
  assign deq   = instr_valid && instr_ready;
  assign flush = run && jmp_valid;
  assign push  = inflight && !flush;

  // Occupancy after this cycle's dequeue, counting the word still coming back from ROM
  assign occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(deq);
  assign issue = run && !jmp_valid && (occ < (CW+1)'(DEPTH));

  assign pc_reset  = !run;
  assign pc_load   = flush;
  assign pc_inc    = issue;
  assign pc_in     = flush ? jmp_target : '0;
  assign imem_addr = pc_out;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_BOOT;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      if (state == S_BOOT) state <= S_RUN;
      inflight <= issue;
      if (issue) inflight_pc <= pc_out;
    end
  end

  fetch_queue #(
    .ENTRY_W (2*WIDTH),
    .DEPTH   (DEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({imem_data, inflight_pc}),
    .pop       (deq),
    .flush     (flush),
    .count     (count),
    .head      (head)
  );

  assign instr_valid = (count != '0);
  assign instr       = head[2*WIDTH-1:WIDTH];
  assign instr_pc    = head[WIDTH-1:0];

`ifdef HACK_FETCH_PERF_EN
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (push)  fetch_cnt <= sat_inc(fetch_cnt);
      if (flush) flush_cnt <= sat_inc(flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_hack_fetch.sv
// Directed bench for hack_fetch with a PC/ROM model and an in-order instruction scoreboard.
module tb_hack_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pc_out;
  logic        pc_reset;
  logic        pc_load;
  logic        pc_inc;
  logic [15:0] pc_in;
  logic [15:0] imem_addr;
  logic [15:0] imem_data = 16'd0;
  logic        jmp_valid;
  logic [15:0] jmp_target;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
`ifdef HACK_FETCH_PERF_EN
  logic [15:0] fetch_cnt;
  logic [15:0] flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  logic [31:0] sb [$];
  logic [15:0] pc_q = 16'd0;

  hack_fetch #(.WIDTH(16), .DEPTH(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc_out      (pc_out),
    .pc_reset    (pc_reset),
    .pc_load     (pc_load),
    .pc_inc      (pc_inc),
    .pc_in       (pc_in),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .jmp_valid   (jmp_valid),
    .jmp_target  (jmp_target),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
`ifdef HACK_FETCH_PERF_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Hack PC register (reset > load > inc) and ROM[i] = i + 100 with one-cycle read latency
  always @(posedge clock) begin
    if (pc_reset)     pc_q <= 16'd0;
    else if (pc_load) pc_q <= pc_in;
    else if (pc_inc)  pc_q <= pc_q + 16'd1;
    imem_data <= imem_addr + 16'd100;
  end
  assign pc_out = pc_q;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t required < 100000", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic refill(input logic [15:0] base);
    logic [15:0] a;
    sb.delete();
    for (int i = 0; i < 64; i++) begin
      a = base + 16'(i);
      sb.push_back({a + 16'd100, a});
    end
  endtask

  // Called at a falling edge with inputs already set; checks any transfer at the coming edge
  task automatic tick();
    logic [31:0] req;
    #1;
    if (instr_valid === 1'b1 && instr_ready) begin
      if (sb.size() != 0) req = sb.pop_front();
      else req = 'x;
      chk("stream", {instr, instr_pc}, req);
      xfers++;
    end
    @(negedge clock);
  endtask

  // Called right after reset release: BOOT cycle, issue of address 0, then first valid
  task automatic boot_check(input string tag);
    #1;
    chk({tag, "_pc_reset_boot"}, 32'(pc_reset), 32'd1);
    chk({tag, "_valid_e0"}, 32'(instr_valid), 32'd0);
    tick();
    #1;
    chk({tag, "_pc_reset_run"}, 32'(pc_reset), 32'd0);
    chk({tag, "_pc_inc_first"}, 32'(pc_inc), 32'd1);
    chk({tag, "_valid_e1"}, 32'(instr_valid), 32'd0);
    tick();
    #1;
    chk({tag, "_valid_e2"}, 32'(instr_valid), 32'd0);
    tick();
    #1;
    chk({tag, "_valid_e3"}, 32'(instr_valid), 32'd1);
    chk({tag, "_instr0"}, 32'(instr), 32'd100);
    chk({tag, "_instr_pc0"}, 32'(instr_pc), 32'd0);
  endtask

  initial begin
    reset       = 1'b0;
    jmp_valid   = 1'b0;
    jmp_target  = 16'd0;
    instr_ready = 1'b1;

    // reset held low for three cycles
    repeat (3) @(negedge clock);
    #1;
    chk("rst_pc_reset", 32'(pc_reset), 32'd1);
    chk("rst_pc_load", 32'(pc_load), 32'd0);
    chk("rst_pc_inc", 32'(pc_inc), 32'd0);
    chk("rst_pc_in", 32'(pc_in), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    @(negedge clock);
    refill(16'd0);
    reset = 1'b1;
    boot_check("boot");

    // steady consumer: one instruction per cycle
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("thru_pc_inc", 32'(pc_inc), 32'd1);
      chk("thru_valid", 32'(instr_valid), 32'd1);
      tick();
    end

    // consumer stalls: queue fills, PC freezes
    instr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("stall_pc_inc", 32'(pc_inc), 32'd0);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      tick();
    end
    instr_ready = 1'b1;
    repeat (4) tick();

    // redirect while an issue is in flight
    jmp_valid  = 1'b1;
    jmp_target = 16'd40;
    #1;
    chk("jmp_pc_load", 32'(pc_load), 32'd1);
    chk("jmp_pc_in", 32'(pc_in), 32'd40);
    chk("jmp_pc_inc", 32'(pc_inc), 32'd0);
    tick();
    refill(16'd40);
    jmp_valid  = 1'b0;
    jmp_target = 16'd0;
    #1;
    chk("jmp_pc_out", 32'(pc_out), 32'd40);
    chk("jmp_valid_e1", 32'(instr_valid), 32'd0);
    tick();
    #1;
    chk("jmp_valid_e2", 32'(instr_valid), 32'd0);
    tick();
    #1;
    chk("jmp_valid_e3", 32'(instr_valid), 32'd1);
    chk("jmp_instr", 32'(instr), 32'd140);
    chk("jmp_instr_pc", 32'(instr_pc), 32'd40);
    repeat (5) tick();

    // reset mid-stream with the queue full
    instr_ready = 1'b0;
    repeat (3) tick();
    #1;
    chk("full_valid", 32'(instr_valid), 32'd1);
    chk("full_pc_inc", 32'(pc_inc), 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_pc_reset", 32'(pc_reset), 32'd1);
    sb.delete();
    repeat (2) @(negedge clock);
    refill(16'd0);
    instr_ready = 1'b1;
    reset = 1'b1;
    boot_check("reboot");

    // five more edges after the first push, then a second redirect
    repeat (5) tick();
`ifdef HACK_FETCH_PERF_EN
    #1;
    chk("perf_fetch_pre", 32'(fetch_cnt), 32'd6);
    chk("perf_flush_pre", 32'(flush_cnt), 32'd0);
`endif
    jmp_valid  = 1'b1;
    jmp_target = 16'd200;
    tick();
    refill(16'd200);
    jmp_valid  = 1'b0;
    jmp_target = 16'd0;
`ifdef HACK_FETCH_PERF_EN
    #1;
    chk("perf_fetch_jmp", 32'(fetch_cnt), 32'd6);
    chk("perf_flush_jmp", 32'(flush_cnt), 32'd1);
`endif
    tick();
    tick();
    #1;
    chk("jmp2_instr", 32'(instr), 32'd300);
    chk("jmp2_instr_pc", 32'(instr_pc), 32'd200);
    repeat (4) tick();
    #1;
    chk("xfers_seen", 32'(xfers > 20), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
